// File: rtl/versatile_fifo_pkg.sv
// Shared types and helpers for the versatile single-clock FIFO: pointer
// comparison, a clog2 helper and the wide level type used for thresholds.
package versatile_fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_t;
  typedef logic [PTR_MAX_W-1:0] level_t;

  typedef struct packed {
    logic full;
    logic empty;
  } ptr_flags_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 32'd0;
    while ((64'd1 << result) < 64'(value)) result = result + 32'd1;
    return result;
  endfunction

  // Pointers carry one extra MSB: equal low bits with differing MSB means full.
  function automatic ptr_flags_t ptr_compare(input ptr_t wr_ptr, input ptr_t rd_ptr,
                                             input int unsigned addr_w);
    ptr_t       lo_mask;
    ptr_t       all_mask;
    ptr_t       diff;
    ptr_flags_t flags;
    lo_mask     = (ptr_t'(1) << addr_w) - ptr_t'(1);
    all_mask    = (lo_mask << 1) | ptr_t'(1);
    diff        = (wr_ptr ^ rd_ptr) & all_mask;
    flags.empty = (diff == ptr_t'(0));
    flags.full  = ((diff & lo_mask) == ptr_t'(0)) && !flags.empty;
    return flags;
  endfunction

endpackage

// File: rtl/versatile_fifo_sc_dw_if.sv
// Handshake and status bundle between the FIFO (slave) and its user (master).
interface versatile_fifo_sc_dw_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/versatile_fifo_dpram_sc.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Kept free of control logic so a vendor macro can drop in its place.
module versatile_fifo_dpram_sc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wadr,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [ADDR_WIDTH-1:0] radr,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wadr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      q <= mem_q[radr];
    end
  end
endmodule

// File: rtl/versatile_fifo_sc_dw.sv
// Parametrised single-clock FIFO with level, threshold and sticky error flags,
// plus an optional first-word-fall-through output stage.
module versatile_fifo_sc_dw
  import versatile_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_LVL = 4
) (
  input logic                   clk,
  input logic                   rst,
  versatile_fifo_sc_dw_if.slave fifo_if
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int LVL_W = clog2(DEPTH) + 1;
  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
  logic                  full_d, empty_d, afull_d, aempty_d;
  logic                  wr_acc_s, mem_we_s, pop_s, ram_re_s;
  logic [DATA_WIDTH-1:0] ram_q_s;
  ptr_flags_t            arr_s;

  assign arr_s    = ptr_compare(ptr_t'(wr_ptr_q), ptr_t'(rd_ptr_q), 32'(ADDR_WIDTH));
  assign wr_acc_s = fifo_if.wr_en && !full_q;
  assign mem_we_s = wr_acc_s && !arr_s.full;

  assign wr_ptr_d = wr_ptr_q + PTR_W'(mem_we_s);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(ram_re_s);
  assign level_d  = level_q + LVL_W'(wr_acc_s) - LVL_W'(pop_s);
  assign full_d   = (level_d == LVL_W'(DEPTH));
  assign empty_d  = (level_d == {LVL_W{1'b0}});
  assign afull_d  = (level_t'(level_d) >= level_t'(AFULL_LVL));
  assign aempty_d = (level_t'(level_d) <= level_t'(AEMPTY_LVL));

  versatile_fifo_dpram_sc #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (mem_we_s),
    .wadr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .d    (fifo_if.wr_data),
    .radr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .re   (ram_re_s),
    .q    (ram_q_s)
  );

  // Pointer, level and flag registers; all flags follow level on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_q | (fifo_if.wr_en & full_q);
      udf_q    <= udf_q | (fifo_if.rd_en & empty_q);
    end
  end

  assign fifo_if.level        = level_q;
  assign fifo_if.full         = full_q;
  assign fifo_if.empty        = empty_q;
  assign fifo_if.almost_full  = afull_q;
  assign fifo_if.almost_empty = aempty_q;
  assign fifo_if.overflow     = ovf_q;
  assign fifo_if.underflow    = udf_q;

  if (FWFT != 0) begin : g_fwft
    // RAM q acts as a middle stage between the array and the head register,
    // so rd_valid marks a present head word and trails !empty by the fill latency.
    logic                  mid_valid_q, out_valid_q, out_take_s;
    logic [DATA_WIDTH-1:0] out_data_q;

    assign pop_s      = fifo_if.rd_en && out_valid_q;
    assign out_take_s = !out_valid_q || pop_s;
    assign ram_re_s   = !arr_s.empty && (!mid_valid_q || out_take_s);

    // Prefetch bookkeeping and head-word register.
    always_ff @(posedge clk) begin
      if (rst) begin
        mid_valid_q <= 1'b0;
        out_valid_q <= 1'b0;
        out_data_q  <= {DATA_WIDTH{1'b0}};
      end else begin
        mid_valid_q <= ram_re_s | (mid_valid_q & ~out_take_s);
        if (out_take_s) begin
          out_valid_q <= mid_valid_q;
          if (mid_valid_q) begin
            out_data_q <= ram_q_s;
          end
        end
      end
    end

    assign fifo_if.rd_data  = out_data_q;
    assign fifo_if.rd_valid = out_valid_q;
  end else begin : g_std
    logic rd_valid_q, seen_q;

    assign pop_s    = fifo_if.rd_en && !empty_q;
    assign ram_re_s = pop_s && !arr_s.empty;

    // Read-valid pulse; seen_q keeps rd_data at zero until the first read.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_valid_q <= 1'b0;
        seen_q     <= 1'b0;
      end else begin
        rd_valid_q <= pop_s;
        seen_q     <= seen_q | pop_s;
      end
    end

    assign fifo_if.rd_data  = seen_q ? ram_q_s : {DATA_WIDTH{1'b0}};
    assign fifo_if.rd_valid = rd_valid_q;
  end
endmodule

// File: tb/tb_versatile_fifo_sc_dw.sv
// Bench for versatile_fifo_sc_dw: a standard and an FWFT instance share stimulus
// and are checked each cycle against queue-based reference models.
module tb_versatile_fifo_sc_dw;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  versatile_fifo_sc_dw_if #(.DATA_WIDTH(8), .ADDR_WIDTH(AW)) if_std ();
  versatile_fifo_sc_dw_if #(.DATA_WIDTH(8), .ADDR_WIDTH(AW)) if_fw ();

  assign if_std.wr_en   = wr_en;
  assign if_std.wr_data = wr_data;
  assign if_std.rd_en   = rd_en;
  assign if_fw.wr_en    = wr_en;
  assign if_fw.wr_data  = wr_data;
  assign if_fw.rd_en    = rd_en;

  versatile_fifo_sc_dw #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .FWFT(0), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL))
    dut_std (.clk(clk), .rst(rst), .fifo_if(if_std));
  versatile_fifo_sc_dw #(.DATA_WIDTH(8), .ADDR_WIDTH(AW), .FWFT(1), .AFULL_LVL(AFL), .AEMPTY_LVL(AEL))
    dut_fw (.clk(clk), .rst(rst), .fifo_if(if_fw));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference models ----------------
  typedef struct packed { logic [7:0] d; int t; } ent_t;
  logic [7:0] sq[$];
  ent_t       fq[$];
  int         edge_n = 0;
  logic       s_valid = 1'b0, s_ovf = 1'b0, s_udf = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       f_vis = 1'b0, f_ovf = 1'b0, f_udf = 1'b0;
  logic [7:0] f_data = 8'h00;
  ent_t       f_new;

  task automatic chk_flags(input string tag, input int lvl, input logic [4:0] a_lvl, input logic a_full,
                           input logic a_empty, input logic a_af, input logic a_ae);
    chk({tag, ".level"}, 32'(a_lvl), lvl);
    chk({tag, ".full"}, 32'(a_full), 32'(lvl == DEPTH));
    chk({tag, ".empty"}, 32'(a_empty), 32'(lvl == 0));
    chk({tag, ".almost_full"}, 32'(a_af), 32'(lvl >= AFL));
    chk({tag, ".almost_empty"}, 32'(a_ae), 32'(lvl <= AEL));
  endtask

  // Model update on each edge, then compare shortly after the edge.
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst) begin
      sq.delete(); fq.delete();
      s_valid = 1'b0; s_data = 8'h00; s_ovf = 1'b0; s_udf = 1'b0;
      f_vis = 1'b0; f_data = 8'h00; f_ovf = 1'b0; f_udf = 1'b0;
    end else begin
      // standard: read returns the oldest word one cycle later
      if (wr_en && sq.size() == DEPTH) s_ovf = 1'b1;
      if (rd_en && sq.size() == 0) s_udf = 1'b1;
      s_valid = rd_en && (sq.size() != 0);
      if (s_valid) s_data = sq.pop_front();
      if (wr_en && sq.size() + (s_valid ? 1 : 0) != DEPTH) sq.push_back(wr_data);
      // fwft: a word is visible at the head two edges after it was written
      if (wr_en && fq.size() == DEPTH) f_ovf = 1'b1;
      if (rd_en && fq.size() == 0) f_udf = 1'b1;
      if (rd_en && f_vis) void'(fq.pop_front());
      if (wr_en && fq.size() + ((rd_en && f_vis) ? 1 : 0) != DEPTH) begin
        f_new.d = wr_data;
        f_new.t = edge_n;
        fq.push_back(f_new);
      end
      f_vis = (fq.size() != 0) && (edge_n >= fq[0].t + 2);
      if (f_vis) f_data = fq[0].d;
    end
    #1;
    chk("std.rd_valid", 32'(if_std.rd_valid), 32'(s_valid));
    chk("std.rd_data", 32'(if_std.rd_data), 32'(s_data));
    chk("std.overflow", 32'(if_std.overflow), 32'(s_ovf));
    chk("std.underflow", 32'(if_std.underflow), 32'(s_udf));
    chk_flags("std", sq.size(), if_std.level, if_std.full, if_std.empty, if_std.almost_full, if_std.almost_empty);
    chk("fw.rd_valid", 32'(if_fw.rd_valid), 32'(f_vis));
    chk("fw.rd_data", 32'(if_fw.rd_data), 32'(f_data));
    chk("fw.overflow", 32'(if_fw.overflow), 32'(f_ovf));
    chk("fw.underflow", 32'(if_fw.underflow), 32'(f_udf));
    chk_flags("fw", fq.size(), if_fw.level, if_fw.full, if_fw.empty, if_fw.almost_full, if_fw.almost_empty);
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int wp;
    int rp;
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("lit.reset.level", 32'(if_std.level), 32'd0);
    chk("lit.reset.empty", 32'(if_std.empty), 32'd1);
    chk("lit.reset.almost_empty", 32'(if_std.almost_empty), 32'd1);
    chk("lit.reset.full", 32'(if_std.full), 32'd0);
    chk("lit.reset.rd_valid", 32'(if_std.rd_valid), 32'd0);
    chk("lit.reset.rd_data", 32'(if_std.rd_data), 32'd0);
    chk("lit.reset.fw_rd_valid", 32'(if_fw.rd_valid), 32'd0);

    // three writes, three reads
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    step(1'b1, 8'hA3, 1'b0);
    chk("lit.abc.level3", 32'(if_std.level), 32'd3);
    step(1'b0, 8'h00, 1'b1);
    chk("lit.abc.rd1", {23'd0, if_std.rd_valid, if_std.rd_data}, {23'd0, 1'b1, 8'hA1});
    step(1'b0, 8'h00, 1'b1);
    chk("lit.abc.rd2", {23'd0, if_std.rd_valid, if_std.rd_data}, {23'd0, 1'b1, 8'hA2});
    step(1'b0, 8'h00, 1'b1);
    chk("lit.abc.rd3", {23'd0, if_std.rd_valid, if_std.rd_data}, {23'd0, 1'b1, 8'hA3});
    chk("lit.abc.level0", 32'(if_std.level), 32'd0);
    chk("lit.abc.empty", 32'(if_std.empty), 32'd1);
    step(1'b0, 8'h00, 1'b0);
    chk("lit.abc.hold", {23'd0, if_std.rd_valid, if_std.rd_data}, {23'd0, 1'b0, 8'hA3});

    // fill, overflow, simultaneous write+read while full, drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("lit.fill.full", 32'(if_std.full), 32'd1);
    chk("lit.fill.level", 32'(if_std.level), 32'd16);
    step(1'b1, 8'hEE, 1'b0);
    chk("lit.fill.overflow", 32'(if_std.overflow), 32'd1);
    step(1'b1, 8'h77, 1'b1);
    chk("lit.fullrw.level", 32'(if_std.level), 32'd15);
    chk("lit.fullrw.data", 32'(if_std.rd_data), 32'h10);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("lit.drain.data", 32'(if_std.rd_data), 32'(8'h10 + i));
    end
    chk("lit.drain.empty", 32'(if_std.empty), 32'd1);

    // read while empty with a simultaneous write
    do_reset();
    step(1'b1, 8'h55, 1'b1);
    chk("lit.udf.underflow", 32'(if_std.underflow), 32'd1);
    chk("lit.udf.level", 32'(if_std.level), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("lit.udf.read", {23'd0, if_std.rd_valid, if_std.rd_data}, {23'd0, 1'b1, 8'h55});

    // FWFT latency and streaming
    do_reset();
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("lit.fwft.k1_valid", 32'(if_fw.rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("lit.fwft.k2_head", {23'd0, if_fw.rd_valid, if_fw.rd_data}, {23'd0, 1'b1, 8'h3C});
    step(1'b0, 8'h00, 1'b1);
    chk("lit.fwft.popped", 32'(if_fw.rd_valid), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("lit.fwft.stream", {23'd0, if_fw.rd_valid, if_fw.rd_data}, {23'd0, 1'b1, 8'(8'h40 + i)});
      step(1'b1, 8'(8'h4A + i), 1'b1);
    end
    for (int i = 0; i < 10; i++) begin
      chk("lit.fwft.stream", {23'd0, if_fw.rd_valid, if_fw.rd_data}, {23'd0, 1'b1, 8'(8'h4A + i)});
      step(1'b0, 8'h00, 1'b1);
    end
    chk("lit.fwft.drained", 32'(if_fw.empty), 32'd1);

    // threshold sweep and mid-operation reset
    do_reset();
    for (int n = 1; n <= DEPTH; n++) begin
      step(1'b1, 8'(n), 1'b0);
      chk("lit.sweep.up_af", 32'(if_std.almost_full), 32'(n >= 12));
      chk("lit.sweep.up_ae", 32'(if_std.almost_empty), 32'(n <= 2));
    end
    step(1'b1, 8'hFF, 1'b0);
    for (int n = DEPTH - 1; n >= 0; n--) begin
      step(1'b0, 8'h00, 1'b1);
      chk("lit.sweep.dn_level", 32'(if_std.level), 32'(n));
      chk("lit.sweep.dn_af", 32'(if_std.almost_full), 32'(n >= 12));
      chk("lit.sweep.dn_ae", 32'(if_std.almost_empty), 32'(n <= 2));
    end
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
    chk("lit.rst9.level", 32'(if_std.level), 32'd9);
    chk("lit.rst9.errors", {30'd0, if_std.overflow, if_std.underflow}, 32'd3);
    do_reset();
    chk("lit.rst9.after_level", 32'(if_std.level), 32'd0);
    chk("lit.rst9.after_empty", 32'(if_std.empty), 32'd1);
    chk("lit.rst9.after_errors", {30'd0, if_std.overflow, if_std.underflow}, 32'd0);

    // randomized traffic with varying bias and occasional reset
    wp = 50;
    rp = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        wp = $urandom_range(90, 10);
        rp = $urandom_range(90, 10);
      end
      rst = ($urandom_range(299, 0) == 0);
      step(($urandom_range(99, 0) < wp), 8'($urandom), ($urandom_range(99, 0) < rp));
    end
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
